// File: rtl/exponent_axi4_lite_master.sv
// AXI4-Lite master that sequences one exponent computation on the peripheral:
// write X, A, START; poll DONE; read P; report the result with a done pulse.
module exponent_axi4_lite_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h7c80_0000,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic        M_AXI_ACLK,
  input  logic        M_AXI_ARESETN,
  input  logic        i_start,
  input  logic [3:0]  i_X,
  input  logic [3:0]  i_A,
  output logic        o_busy,
  output logic        o_done,
  output logic [14:0] o_P,
  output logic        o_error,
  output logic        o_timeout,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  localparam logic [31:0] OFS_X     = 32'h00;
  localparam logic [31:0] OFS_A     = 32'h04;
  localparam logic [31:0] OFS_START = 32'h08;
  localparam logic [31:0] OFS_P     = 32'h0C;
  localparam logic [31:0] OFS_DONE  = 32'h10;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_X, S_WR_A, S_WR_START, S_GAP, S_RD_DONE, S_RD_P, S_FINISH
  } state_e;

  state_e      state_q;
  logic [3:0]  a_q;
  logic [31:0] awaddr_q, wdata_q, araddr_q;
  logic [3:0]  wstrb_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic        aw_ok_q, w_ok_q, ar_ok_q;
  logic [15:0] poll_q;
  logic        gap_q, err_q, tmo_q;
  logic        busy_q, done_q, error_q, timeout_q;
  logic [14:0] p_q;

  logic [31:0] wr_addr_d, wr_data_d;
  logic [15:0] poll_inc;
  logic        poll_exhausted;
  logic        aw_fire, w_fire, ar_fire, b_hs, r_hs;
  logic        unused_rdata;

  assign aw_fire = awvalid_q & M_AXI_AWREADY;
  assign w_fire  = wvalid_q & M_AXI_WREADY;
  assign ar_fire = arvalid_q & M_AXI_ARREADY;
  // A response only counts once its request(s) were accepted on an earlier edge.
  assign b_hs    = bready_q & M_AXI_BVALID & aw_ok_q & w_ok_q;
  assign r_hs    = rready_q & M_AXI_RVALID & ar_ok_q;

  assign poll_inc       = poll_q + 16'd1;
  assign poll_exhausted = ({16'd0, poll_inc} >= POLL_LIMIT);
  assign unused_rdata   = ^M_AXI_RDATA[31:15];

  // Address/data of the write launched on leaving the current state.
  always_comb begin
    wr_addr_d = BASE_ADDR + OFS_X;
    wr_data_d = {28'd0, i_X};
    case (state_q)
      S_WR_X: begin
        wr_addr_d = BASE_ADDR + OFS_A;
        wr_data_d = {28'd0, a_q};
      end
      S_WR_A: begin
        wr_addr_d = BASE_ADDR + OFS_START;
        wr_data_d = 32'h1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      aw_ok_q   <= 1'b0;
      w_ok_q    <= 1'b0;
      ar_ok_q   <= 1'b0;
      poll_q    <= '0;
      gap_q     <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      p_q       <= '0;
    end else begin
      done_q <= 1'b0;
      if (aw_fire) begin
        awvalid_q <= 1'b0;
        aw_ok_q   <= 1'b1;
      end
      if (w_fire) begin
        wvalid_q <= 1'b0;
        w_ok_q   <= 1'b1;
      end
      if (ar_fire) begin
        arvalid_q <= 1'b0;
        ar_ok_q   <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          // busy_q is still set only during the o_done cycle; starts there are dropped.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (i_start) begin
            busy_q    <= 1'b1;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            tmo_q     <= 1'b0;
            poll_q    <= '0;
            a_q       <= i_A;
            awaddr_q  <= wr_addr_d;
            wdata_q   <= wr_data_d;
            wstrb_q   <= 4'hF;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
            bready_q  <= 1'b1;
            aw_ok_q   <= 1'b0;
            w_ok_q    <= 1'b0;
            state_q   <= S_WR_X;
          end
        end
        S_WR_X, S_WR_A, S_WR_START: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            if (M_AXI_BRESP != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= S_FINISH;
            end else if (state_q == S_WR_START) begin
              gap_q   <= 1'b0;
              state_q <= S_GAP;
            end else begin
              awaddr_q  <= wr_addr_d;
              wdata_q   <= wr_data_d;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              bready_q  <= 1'b1;
              aw_ok_q   <= 1'b0;
              w_ok_q    <= 1'b0;
              state_q   <= (state_q == S_WR_X) ? S_WR_A : S_WR_START;
            end
          end
        end
        S_GAP: begin
          gap_q <= 1'b1;
          if (gap_q) begin
            araddr_q  <= BASE_ADDR + OFS_DONE;
            arvalid_q <= 1'b1;
            rready_q  <= 1'b1;
            ar_ok_q   <= 1'b0;
            state_q   <= S_RD_DONE;
          end
        end
        S_RD_DONE: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            poll_q   <= poll_inc;
            if (M_AXI_RRESP != 2'b00) begin
              err_q   <= 1'b1;
              state_q <= S_FINISH;
            end else if (M_AXI_RDATA[0]) begin
              araddr_q  <= BASE_ADDR + OFS_P;
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
              ar_ok_q   <= 1'b0;
              state_q   <= S_RD_P;
            end else if (poll_exhausted) begin
              tmo_q   <= 1'b1;
              state_q <= S_FINISH;
            end else begin
              arvalid_q <= 1'b1;
              rready_q  <= 1'b1;
              ar_ok_q   <= 1'b0;
            end
          end
        end
        S_RD_P: begin
          if (r_hs) begin
            rready_q <= 1'b0;
            if (M_AXI_RRESP != 2'b00) err_q <= 1'b1;
            else                      p_q   <= M_AXI_RDATA[14:0];
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          done_q    <= 1'b1;
          error_q   <= err_q;
          timeout_q <= tmo_q;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_P           = p_q;
  assign o_error       = error_q;
  assign o_timeout     = timeout_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: doc/exponent_axi4_lite_master.md
# exponent_axi4_lite_master

AXI4-Lite master sequencer that drives the memory-mapped exponent peripheral from fabric logic without a processor. On a single start request it writes X, A and START, polls the DONE register until set or a poll limit is hit, reads P, and returns the result with a one-cycle completion pulse. It sits on the initiator side of the peripheral's AXI4-Lite port, in place of the CPU bus.

## Interface
- BASE_ADDR, 32'h7c800000, peripheral base; register offsets are X +0x00, A +0x04, START +0x08, P +0x0C, DONE +0x10
- POLL_LIMIT, 1024, maximum DONE reads before timeout (16-bit counter, 1..65535)
- M_AXI_ACLK  in  1  single clock; all logic on rising edge
- M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low
- i_start  in  1  request; sampled only in IDLE
- i_X, i_A  in  4 each  operands, latched on accepted i_start
- o_busy  out  1  high from accepted i_start until o_done cycle inclusive
- o_done  out  1  one-cycle completion pulse
- o_P  out  15  result; updated only on successful completion, held otherwise
- o_error  out  1  set on completion if any BRESP/RRESP != 2'b00; cleared on next accepted i_start
- o_timeout  out  1  set on completion if POLL_LIMIT exhausted; cleared on next accepted i_start
- M_AXI_AWADDR out 32, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1
- M_AXI_ARADDR out 32, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1

## Operation
- States: IDLE -> WR_X -> WR_A -> WR_START -> GAP -> RD_DONE -> RD_P -> FINISH -> IDLE
- Write states: in entry cycle assert AWVALID and WVALID together with AWADDR = BASE_ADDR+offset, WDATA = {28'b0, operand} (START: 32'h1), WSTRB = 4'hF
- Each VALID stays high until its own READY is sampled high, then drops; AWADDR/WDATA stable while VALID high
- BREADY high from entry of a write state until B handshake; advance on B handshake only after both AW and W are accepted (B before both accepted is a protocol violation, ignored)
- GAP: 2 idle cycles after START B handshake before first DONE read
- RD_DONE: ARVALID with ARADDR = BASE_ADDR+0x10 until ARREADY; RREADY high until R handshake; poll count +1 per R handshake
- RDATA[0]=1 -> RD_P; RDATA[0]=0 and count < POLL_LIMIT -> reissue read next cycle; count = POLL_LIMIT -> FINISH with timeout
- RD_P: same read sequence at +0x0C; on R handshake capture RDATA[14:0] into o_P (bits 31:15 ignored)
- Any non-OKAY response: record error, abort remaining steps, go to FINISH; o_P unchanged
- FINISH: assert o_done for exactly one cycle, update o_error/o_timeout, return to IDLE
- i_start while busy: ignored, no queuing

## Timing
- Reset (asynchronous, any state including mid-transaction): state IDLE; all VALIDs, BREADY, RREADY, o_busy, o_done, o_error, o_timeout = 0; o_P = 0; AWADDR/ARADDR/WDATA = 0; WSTRB = 0; poll count = 0
- Accepted i_start at edge N: AWVALID/WVALID high from N+1
- Zero-wait responder (READYs high, B/R valid one cycle after acceptance): each write 2 cycles, each read 2 cycles, GAP 2; with DONE on first poll, o_done asserted at cycle N+13
- o_busy drops the cycle after o_done
- AW and W accepted in same cycle or different cycles, either order: both legal
- Never more than one outstanding transaction; AR never overlaps a write

## Test plan
- X=3, A=2, zero-wait responder, DONE=1 on 1st poll, P=0x0009 -> writes 0x7c800000/3, 0x7c800004/2, 0x7c800008/1; reads 0x7c800010 then 0x7c80000C; o_P=0x0009, o_done at N+13, o_error=o_timeout=0
- AWREADY delayed 3 cycles, WREADY immediate (then reversed) -> VALIDs held independently, AWADDR/WDATA stable, exactly one B accepted per write, same o_P
- DONE returns 0 on 4 polls then 1 -> exactly 5 DONE reads, o_P correct
- POLL_LIMIT=4, DONE stuck 0 -> exactly 4 DONE reads, no P read, o_timeout=1, o_P unchanged
- BRESP=2'b10 on A write -> no START write, o_error=1, o_done pulse; next start clears flags and completes normally
- Reset asserted while ARVALID high -> all outputs to reset values immediately; i_start after release runs full sequence; i_start pulses while busy ignored
